// File: rtl/program_loader.sv
// program_loader: host-side stream loader for the accelerator core.
// It decodes 24-bit command headers arriving on a valid/ready stream.
// It writes payload words into the instruction store or the data memory.
// A GO header pulses core_start and holds the host off until the core halts.
module program_loader #(
    parameter int NUM_INSTRUCTIONS = 16,
    parameter int WORDS_IN_MEMORY  = 32,
    parameter int NUM_SIZE         = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [23:0]                         in_data,
    output logic                                imem_we,
    output logic [$clog2(NUM_INSTRUCTIONS)-1:0] imem_addr,
    output logic [23:0]                         imem_wdata,
    output logic                                dmem_we,
    output logic [$clog2(WORDS_IN_MEMORY)-1:0]  dmem_addr,
    output logic [NUM_SIZE-1:0]                 dmem_wdata,
    output logic                                core_start,
    input  logic                                core_halted,
    output logic                                busy,
    output logic                                err
);

    localparam int IAW = $clog2(NUM_INSTRUCTIONS);
    localparam int DAW = $clog2(WORDS_IN_MEMORY);

    localparam logic [3:0] CMD_LOAD_I = 4'd1;
    localparam logic [3:0] CMD_LOAD_D = 4'd2;
    localparam logic [3:0] CMD_GO     = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  base_q, base_nxt;
    logic [4:0]  cnt_q, cnt_nxt;
    logic [4:0]  idx_q, idx_nxt;
    logic        run_seen_q;
    logic        err_set;
    logic        wr_i, wr_d;
    logic        accept;
    logic [3:0]  hdr_cmd;
    logic [4:0]  hdr_base;
    logic [4:0]  hdr_cnt;
    logic [31:0] hdr_last;
    logic        i_fits, d_fits;
    logic [4:0]  waddr;

    assign accept   = in_valid && in_ready;
    assign hdr_cmd  = in_data[23:20];
    assign hdr_base = in_data[19:15];
    assign hdr_cnt  = in_data[14:10];
    assign hdr_last = 32'(hdr_base) + 32'(hdr_cnt);
    assign i_fits   = hdr_last < 32'(NUM_INSTRUCTIONS);
    assign d_fits   = hdr_last < 32'(WORDS_IN_MEMORY);
    assign waddr    = base_q + idx_q;

    // Handshake and status outputs follow directly from the registered state.
    always_comb begin
        in_ready   = (state != S_RUN);
        busy       = (state != S_IDLE);
        core_start = (state == S_RUN) && !run_seen_q;
    end

    // Next-state decode: header handling in IDLE, payload counting in LOAD, halt wait in RUN.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        err_set   = 1'b0;
        wr_i      = 1'b0;
        wr_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (hdr_cmd)
                        CMD_LOAD_I: begin
                            if (i_fits) begin
                                base_nxt  = hdr_base;
                                cnt_nxt   = hdr_cnt;
                                idx_nxt   = '0;
                                state_nxt = S_LOAD_I;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        CMD_LOAD_D: begin
                            if (d_fits) begin
                                base_nxt  = hdr_base;
                                cnt_nxt   = hdr_cnt;
                                idx_nxt   = '0;
                                state_nxt = S_LOAD_D;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        CMD_GO:  state_nxt = S_RUN;
                        default: err_set = 1'b1;
                    endcase
                end
            end
            S_LOAD_I, S_LOAD_D: begin
                if (accept) begin
                    wr_i = (state == S_LOAD_I);
                    wr_d = (state == S_LOAD_D);
                    if (idx_q == cnt_q) begin
                        idx_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx_q + 5'd1;
                    end
                end
            end
            S_RUN: begin
                // The halted level is only trusted from the second RUN cycle on,
                // so a level left over from the previous run cannot end this one.
                if (run_seen_q && core_halted) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, header fields, sticky error and the registered memory write ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            run_seen_q <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state      <= state_nxt;
            base_q     <= base_nxt;
            cnt_q      <= cnt_nxt;
            idx_q      <= idx_nxt;
            run_seen_q <= (state == S_RUN);
            if (err_set) begin
                err <= 1'b1;
            end
            imem_we <= wr_i;
            dmem_we <= wr_d;
            if (wr_i) begin
                imem_addr  <= IAW'(waddr);
                imem_wdata <= in_data;
            end
            if (wr_d) begin
                dmem_addr  <= DAW'(waddr);
                dmem_wdata <= in_data[NUM_SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed, table-driven checks of program_loader.
// There are hand-written sequences for the long RUN wait and for reset in the middle of a load.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic        dmem_we;
    logic [4:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic        core_start;
    logic        core_halted;
    logic        busy;
    logic        err;

    int checks;
    int failures;

    program_loader #(
        .NUM_INSTRUCTIONS(16),
        .WORDS_IN_MEMORY (32),
        .NUM_SIZE        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .core_start (core_start),
        .core_halted(core_halted),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        h;
        logic        rdy;
        logic        bsy;
        logic        st;
        logic        er;
        logic        iwe;
        logic [3:0]  ia;
        logic [23:0] iw;
        logic        dwe;
        logic [4:0]  da;
        logic [15:0] dw;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in: v d h | out: rdy busy start err | iwe ia iw | dwe da dw
        // LOAD_I base=0 cnt_m1=3, back-to-back payloads
        vecs[0]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[1]  = '{1'b1, 24'h100C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[2]  = '{1'b1, 24'h040000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[3]  = '{1'b1, 24'h040001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  24'h040000, 1'b0, 5'd0, 16'h0000};
        vecs[4]  = '{1'b1, 24'h040002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  24'h040001, 1'b0, 5'd0, 16'h0000};
        vecs[5]  = '{1'b1, 24'h040003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  24'h040002, 1'b0, 5'd0, 16'h0000};
        vecs[6]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  24'h040003, 1'b0, 5'd0, 16'h0000};
        vecs[7]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        // LOAD_D base=8 cnt_m1=1 with a 3-cycle valid gap
        vecs[8]  = '{1'b1, 24'h240400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[9]  = '{1'b1, 24'hAB1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[10] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b1, 5'd8, 16'h1234};
        vecs[11] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[12] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[13] = '{1'b1, 24'h005678, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[14] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b1, 5'd9, 16'h5678};
        // LOAD_D base=30 cnt_m1=3 out of range
        vecs[15] = '{1'b1, 24'h2F0C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[16] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[17] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        // LOAD_I base=12 cnt_m1=3 ends exactly at the last entry
        vecs[18] = '{1'b1, 24'h160C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[19] = '{1'b1, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[20] = '{1'b1, 24'h000001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 24'h123456, 1'b0, 5'd0, 16'h0000};
        vecs[21] = '{1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 24'h000001, 1'b0, 5'd0, 16'h0000};
        vecs[22] = '{1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd14, 24'hFFFFFF, 1'b0, 5'd0, 16'h0000};
        vecs[23] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 24'hABCDEF, 1'b0, 5'd0, 16'h0000};
        // illegal cmd 7, then LOAD_I base=13 cnt_m1=3 (one past the end)
        vecs[24] = '{1'b1, 24'h700000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[25] = '{1'b1, 24'h168C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[26] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        // GO with core_halted held high
        vecs[27] = '{1'b1, 24'h300000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[28] = '{1'b1, 24'h040000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[29] = '{1'b1, 24'h040000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[30] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};
        vecs[31] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  24'h000000, 1'b0, 5'd0, 16'h0000};

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        core_halted = 1'b0;

        // reset values while rst is held
        step();
        chk("rst_ready", 0, 32'(in_ready), 32'd1);
        chk("rst_busy",  0, 32'(busy), 32'd0);
        chk("rst_err",   0, 32'(err), 32'd0);
        chk("rst_start", 0, 32'(core_start), 32'd0);
        chk("rst_iwe",   0, 32'(imem_we), 32'd0);
        chk("rst_dwe",   0, 32'(dmem_we), 32'd0);
        chk("rst_iaddr", 0, 32'(imem_addr), 32'd0);
        chk("rst_daddr", 0, 32'(dmem_addr), 32'd0);
        chk("rst_iwd",   0, 32'(imem_wdata), 32'd0);
        chk("rst_dwd",   0, 32'(dmem_wdata), 32'd0);
        step();
        rst = 1'b0;
        step();

        // table-driven sequence
        for (int unsigned i = 0; i < NV; i++) begin
            in_valid    = vecs[i].v;
            in_data     = vecs[i].d;
            core_halted = vecs[i].h;
            #2;
            chk("in_ready",   int'(i), 32'(in_ready),   32'(vecs[i].rdy));
            chk("busy",       int'(i), 32'(busy),       32'(vecs[i].bsy));
            chk("core_start", int'(i), 32'(core_start), 32'(vecs[i].st));
            chk("err",        int'(i), 32'(err),        32'(vecs[i].er));
            chk("imem_we",    int'(i), 32'(imem_we),    32'(vecs[i].iwe));
            chk("dmem_we",    int'(i), 32'(dmem_we),    32'(vecs[i].dwe));
            if (vecs[i].iwe) begin
                chk("imem_addr",  int'(i), 32'(imem_addr),  32'(vecs[i].ia));
                chk("imem_wdata", int'(i), 32'(imem_wdata), 32'(vecs[i].iw));
            end
            if (vecs[i].dwe) begin
                chk("dmem_addr",  int'(i), 32'(dmem_addr),  32'(vecs[i].da));
                chk("dmem_wdata", int'(i), 32'(dmem_wdata), 32'(vecs[i].dw));
            end
            step();
        end

        // GO, core_halted rises 10 cycles after entry
        in_valid    = 1'b1;
        in_data     = 24'h300000;
        core_halted = 1'b0;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        for (int unsigned c = 0; c < 10; c++) begin
            #2;
            chk("go_ready", 100 + int'(c), 32'(in_ready), 32'd0);
            chk("go_busy",  100 + int'(c), 32'(busy), 32'd1);
            chk("go_start", 100 + int'(c), 32'(core_start), (c == 0) ? 32'd1 : 32'd0);
            step();
        end
        core_halted = 1'b1;
        #2;
        chk("go_ready_halt", 110, 32'(in_ready), 32'd0);
        step();
        core_halted = 1'b0;
        #2;
        chk("go_ready_after", 111, 32'(in_ready), 32'd1);
        chk("go_busy_after",  111, 32'(busy), 32'd0);
        step();

        // reset after 2 of 4 LOAD_I payloads
        in_valid = 1'b1;
        in_data  = 24'h100C00;
        step();
        in_data = 24'h0A0000;
        step();
        in_data = 24'h0A0001;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk("mid_iwe",   200, 32'(imem_we), 32'd1);
        chk("mid_iaddr", 200, 32'(imem_addr), 32'd1);
        chk("mid_busy",  200, 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", 201, 32'(in_ready), 32'd1);
        chk("arst_busy",  201, 32'(busy), 32'd0);
        chk("arst_iwe",   201, 32'(imem_we), 32'd0);
        chk("arst_iaddr", 201, 32'(imem_addr), 32'd0);
        chk("arst_iwd",   201, 32'(imem_wdata), 32'd0);
        chk("arst_err",   201, 32'(err), 32'd0);
        #1;
        rst = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 24'h200000;
        step();
        in_data = 24'h12BEEF;
        #2;
        chk("post_hdr_iwe",  202, 32'(imem_we), 32'd0);
        chk("post_hdr_busy", 202, 32'(busy), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk("post_dwe",   203, 32'(dmem_we), 32'd1);
        chk("post_daddr", 203, 32'(dmem_addr), 32'd0);
        chk("post_dwd",   203, 32'(dmem_wdata), 32'h0000BEEF);
        chk("post_busy",  203, 32'(busy), 32'd0);
        chk("post_err",   203, 32'(err), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time limit so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
